// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the 2-way, 4-set, one-word-per-line
// data cache controller.
package dcache_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TAG_W   = 28;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned SETS    = 4;
   localparam int unsigned IDX_LSB = 2;
   localparam int unsigned TAG_LSB = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_ALLOC_REQ,
      S_ALLOC_WAIT
   } state_t;

   function automatic logic [ADDR_W-1:0] compose_addr(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx);
      return {tag, idx, 2'b00};
   endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU bits and victim selection: an invalid way is preferred, otherwise
// the way named by the set's LRU bit.
module dcache_lru
   import dcache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] idx,
   input  logic             v_way0,
   input  logic             v_way1,
   input  logic             upd_en,
   input  logic             upd_way,
   output logic             victim
);

   logic [SETS-1:0] lru;

   // The stored bit names the way to evict next, i.e. the one not just used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lru <= '0;
      end else if (upd_en) begin
         lru[idx] <= ~upd_way;
      end
   end

   always_comb begin
      victim = lru[idx];
      if (!v_way0) begin
         victim = 1'b0;
      end else if (!v_way1) begin
         victim = 1'b1;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for the 2-way x 4-set cache array:
// tag compare, victim writeback, refill and CPU response sequencing.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_we,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_req_ready,
   output logic              cpu_resp_valid,
   output logic [DATA_W-1:0] cpu_resp_rdata,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic              arr_write_en,
   output logic [IDX_W-1:0]  arr_index,
   output logic              arr_victim_way,
   output logic              arr_v_write,
   output logic [TAG_W-1:0]  arr_tag_write,
   output logic [DATA_W-1:0] arr_data_write,
   output logic              arr_dirty_write,
   input  logic              arr_v_way0,
   input  logic              arr_v_way1,
   input  logic              arr_dirty_way0,
   input  logic              arr_dirty_way1,
   input  logic [TAG_W-1:0]  arr_tag_way0,
   input  logic [TAG_W-1:0]  arr_tag_way1,
   input  logic [DATA_W-1:0] arr_data_way0,
   input  logic [DATA_W-1:0] arr_data_way1
);

   state_t             state;
   logic               req_we;
   logic [TAG_W-1:0]   req_tag;
   logic [IDX_W-1:0]   req_idx;
   logic [DATA_W-1:0]  req_wdata;
   logic               victim_q;
   logic [TAG_W-1:0]   vic_tag;
   logic [DATA_W-1:0]  vic_data;
   logic               resp_pend;
   logic               hit0, hit1, hit, hit_way;
   logic               victim, vic_dirty;
   logic               in_compare, in_wait;
   logic               lru_upd_en, lru_upd_way;
   logic               unused_addr_bits;

   assign unused_addr_bits = &{1'b0, cpu_req_addr[IDX_LSB-1:0]};

   assign in_compare = (state == S_COMPARE);
   assign in_wait    = (state == S_ALLOC_WAIT);

   assign hit0    = arr_v_way0 && (arr_tag_way0 == req_tag);
   assign hit1    = arr_v_way1 && (arr_tag_way1 == req_tag);
   assign hit     = hit0 || hit1;
   assign hit_way = !hit0;

   assign vic_dirty = victim ? (arr_v_way1 && arr_dirty_way1) : (arr_v_way0 && arr_dirty_way0);

   assign lru_upd_en  = (in_compare && hit) || (in_wait && mem_resp_valid);
   assign lru_upd_way = in_compare ? hit_way : victim_q;

   dcache_lru u_lru (
      .clk     (clk),
      .rst     (rst),
      .idx     (req_idx),
      .v_way0  (arr_v_way0),
      .v_way1  (arr_v_way1),
      .upd_en  (lru_upd_en),
      .upd_way (lru_upd_way),
      .victim  (victim)
   );

   assign cpu_req_ready = (state == S_IDLE);

   // Memory side decodes straight from the state register so an async reset drops it at once.
   assign mem_req_valid = (state == S_WRITEBACK) || (state == S_ALLOC_REQ);
   assign mem_req_we    = (state == S_WRITEBACK);
   assign mem_req_addr  = (state == S_WRITEBACK) ? compose_addr(vic_tag, req_idx)
                                                 : compose_addr(req_tag, req_idx);
   assign mem_req_wdata = vic_data;

   assign arr_index       = req_idx;
   assign arr_write_en    = (in_compare && hit && req_we) || (in_wait && mem_resp_valid);
   assign arr_victim_way  = in_compare ? hit_way : victim_q;
   assign arr_v_write     = 1'b1;
   assign arr_tag_write   = req_tag;
   assign arr_dirty_write = req_we;
   assign arr_data_write  = (in_wait && !req_we) ? mem_resp_rdata : req_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         req_we         <= 1'b0;
         req_tag        <= '0;
         req_idx        <= '0;
         req_wdata      <= '0;
         victim_q       <= 1'b0;
         vic_tag        <= '0;
         vic_data       <= '0;
         resp_pend      <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_rdata <= '0;
      end else begin
         cpu_resp_valid <= resp_pend;
         resp_pend      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cpu_req_valid) begin
                  req_we    <= cpu_req_we;
                  req_tag   <= cpu_req_addr[ADDR_W-1:TAG_LSB];
                  req_idx   <= cpu_req_addr[TAG_LSB-1:IDX_LSB];
                  req_wdata <= cpu_req_wdata;
                  state     <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               if (hit) begin
                  resp_pend      <= 1'b1;
                  cpu_resp_rdata <= req_we ? req_wdata : (hit0 ? arr_data_way0 : arr_data_way1);
                  state          <= S_IDLE;
               end else begin
                  victim_q <= victim;
                  vic_tag  <= victim ? arr_tag_way1 : arr_tag_way0;
                  vic_data <= victim ? arr_data_way1 : arr_data_way0;
                  state    <= vic_dirty ? S_WRITEBACK : S_ALLOC_REQ;
               end
            end
            S_WRITEBACK: begin
               if (mem_req_ready) begin
                  state <= S_ALLOC_REQ;
               end
            end
            S_ALLOC_REQ: begin
               if (mem_req_ready) begin
                  state <= S_ALLOC_WAIT;
               end
            end
            S_ALLOC_WAIT: begin
               if (mem_resp_valid) begin
                  resp_pend      <= 1'b1;
                  cpu_resp_rdata <= arr_data_write;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   a_single_hit: assert property (@(posedge clk) disable iff (rst)
      (state == S_COMPARE) |-> !(hit0 && hit1));

endmodule
